// File: rtl/y86_pkg.sv
// Shared Y86-64 execute-stage constants: ALU function codes, jXX/cmovXX
// condition codes and the instruction codes seen by the ALU function decoder.
package y86_pkg;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_XOR = 2'b11;

    localparam logic [3:0] C_YES = 4'h0;
    localparam logic [3:0] C_LE  = 4'h1;
    localparam logic [3:0] C_L   = 4'h2;
    localparam logic [3:0] C_E   = 4'h3;
    localparam logic [3:0] C_NE  = 4'h4;
    localparam logic [3:0] C_GE  = 4'h5;
    localparam logic [3:0] C_G   = 4'h6;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

endpackage

// File: rtl/cond_eval.sv
// Combinational jXX/cmovXX condition evaluation from the ZF/SF/OF flags.
import y86_pkg::*;

module cond_eval (
    input  logic       zf,
    input  logic       sf,
    input  logic       of,
    input  logic [3:0] cond_fun,
    output logic       cnd
);

    logic lt;

    always_comb begin
        lt  = sf ^ of;
        cnd = 1'b0;
        case (cond_fun)
            C_YES:   cnd = 1'b1;
            C_LE:    cnd = lt | zf;
            C_L:     cnd = lt;
            C_E:     cnd = zf;
            C_NE:    cnd = ~zf;
            C_GE:    cnd = ~lt;
            C_G:     cnd = ~lt & ~zf;
            default: cnd = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with condition-code register and a one-entry registered
// output buffer on a valid/ready handshake.
import y86_pkg::*;

module alu_exec_unit #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [1:0]   aluFun,
    input  logic [W-1:0] aluA,
    input  logic [W-1:0] aluB,
    input  logic         set_cc,
    input  logic [3:0]   cond_fun,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] valE,
    output logic         cnd,
    output logic         cc_zf,
    output logic         cc_sf,
    output logic         cc_of
);

    logic [W-1:0] t;
    logic         t_of;
    logic         cnd_now;
    logic         accept;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        t    = '0;
        t_of = 1'b0;
        case (aluFun)
            ALU_ADD: begin
                t    = aluB + aluA;
                t_of = (aluA[W-1] == aluB[W-1]) && (t[W-1] != aluA[W-1]);
            end
            ALU_SUB: begin
                t    = aluB - aluA;
                t_of = (aluA[W-1] != aluB[W-1]) && (t[W-1] != aluB[W-1]);
            end
            ALU_AND: t = aluB & aluA;
            default: t = aluB ^ aluA;
        endcase
    end

    // Condition sees the flags left by the previous setting op, not this one.
    cond_eval u_cond_eval (
        .zf       (cc_zf),
        .sf       (cc_sf),
        .of       (cc_of),
        .cond_fun (cond_fun),
        .cnd      (cnd_now)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            valE      <= '0;
            cnd       <= 1'b0;
            cc_zf     <= 1'b1;
            cc_sf     <= 1'b0;
            cc_of     <= 1'b0;
        end else begin
            if (accept) begin
                out_valid <= 1'b1;
                valE      <= t;
                cnd       <= cnd_now;
                if (set_cc) begin
                    cc_zf <= (t == '0);
                    cc_sf <= t[W-1];
                    cc_of <= t_of;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
Execute-stage ALU that consumes the 2-bit aluFun code produced by the ALU function decoder, plus operands aluA/aluB. It computes valE, maintains the architectural condition-code register (ZF/SF/OF), and evaluates the jXX/cmovXX condition (Cnd). Inputs arrive on a valid/ready handshake. Results leave through a one-entry registered output buffer, which lets the block sit between decode/fetch logic and a stalled write-back or memory stage.

Parameters:
W, 64, datapath width in bits (Y86-64 word).

Ports:
clk  in  1  system clock; all state updates on the rising edge
rst  in  1  synchronous reset, active-high
in_valid  in  1  operation presented this cycle
in_ready  out  1  unit can accept an operation this cycle
aluFun  in  2  00 add, 01 sub, 10 and, 11 xor
aluA  in  W  operand A
aluB  in  W  operand B
set_cc  in  1  update the CC register with this operation's flags (OPq only)
cond_fun  in  4  condition code for Cnd (instruction ifun)
out_valid  out  1  valE/cnd hold a valid result
out_ready  in  1  consumer takes the result this cycle
valE  out  W  registered ALU result
cnd  out  1  registered condition outcome
cc_zf  out  1  current zero flag
cc_sf  out  1  current sign flag
cc_of  out  1  current overflow flag

Behaviour:
- Reset (rst=1 at a rising edge), applied to every output:
  - out_valid=0, valE=0, cnd=0.
  - cc_zf=1, cc_sf=0, cc_of=0.
  - Reset overrides any concurrent accept, drain or set_cc, so a buffered result is discarded.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Accept occurs when in_valid && in_ready.
  - Drain occurs when out_valid && out_ready.
  - While in_valid=1 and in_ready=0, the source holds its inputs stable; the unit ignores them.
- Latency and throughput:
  - Accept at edge N → out_valid=1 and valE/cnd valid after edge N.
  - Throughput is 1 op/cycle when out_ready is held high.
  - Simultaneous accept and drain: the new result replaces the old and out_valid stays 1.
  - Drain without accept: out_valid→0; valE and cnd hold their last values.
- Arithmetic (Y86 operand order, modulo 2^W):
  - add: t = aluB + aluA.
  - sub: t = aluB − aluA.
  - and: t = aluB & aluA.
  - xor: t = aluB ^ aluA.
- Flags of t:
  - ZF = (t==0).
  - SF = t[W-1].
  - OF for add = (aluA[W-1]==aluB[W-1]) && (t[W-1]!=aluA[W-1]).
  - OF for sub = (aluA[W-1]!=aluB[W-1]) && (t[W-1]!=aluB[W-1]).
  - OF for and/xor = 0.
- CC register:
  - Written only on an accept with set_cc=1.
  - set_cc without accept is ignored.
- Cnd timing: evaluated from the CC value before this operation's own update, i.e. the flags left by the prior setting instruction.
- Cnd truth table by cond_fun:
  - 0 always → 1
  - 1 le → (SF^OF)|ZF
  - 2 l → SF^OF
  - 3 e → ZF
  - 4 ne → !ZF
  - 5 ge → !(SF^OF)
  - 6 g → !(SF^OF)&!ZF
  - 7–F → 0
- Back-to-back dependency: a set_cc op accepted at edge N followed by a cmov/jXX accepted at edge N+1 evaluates against the updated flags. No extra bypass is needed because the CC register is already written.

Decomposition:
- Shared package y86_pkg holds:
  - ALU code constants ALU_ADD/ALU_SUB/ALU_AND/ALU_XOR (2-bit).
  - Condition constants C_YES, C_LE, C_L, C_E, C_NE, C_GE, C_G (4-bit).
  - icode constants used by the ALU function decoder.
- One combinational sub-module, cond_eval: inputs zf, sf, of and cond_fun; output cnd. It is reusable by a future branch predictor/PC-select block.

Test Plan:
1. Reset: assert rst for 2 cycles with in_valid=1 → out_valid=0, valE=0, cnd=0, ZF=1, SF=0, OF=0.
2. Add overflow: aluFun=00, A=B=0x4000000000000000, set_cc=1 → valE=0x8000000000000000, next-cycle ZF=0, SF=1, OF=1.
3. Sub and conditions:
   - Sub: A=5, B=5, set_cc=1 → valE=0, ZF=1, SF=0, OF=0.
   - Following op with cond_fun=3 (e) → cnd=1.
   - Following op with cond_fun=4 (ne) → cnd=0.
4. And/xor flags: with prior OF=1, and A=0xFF, B=0x0F, set_cc=1 → valE=0x0F, OF cleared to 0. xor A=B=0x1234 with set_cc=0 → valE=0, CC unchanged.
5. Backpressure: hold out_ready=0 after one accept.
   - in_ready=0 and a second op is held for 3 cycles; valE stays at the first result.
   - Raising out_ready → same-cycle accept; the second result appears next cycle.
6. Reset mid-operation: out_valid=1 with out_ready=0, then pulse rst → out_valid=0 and CC returns to ZF=1, SF=0, OF=0; the pending result is never presented.
